// File: rtl/sha256_byte_host.sv
// Host driver for the 8-bit SHA-256 pin interface: streams a 512-bit block
// as 64 byte writes, waits for hash_ready, then reads back the 256-bit digest.
module sha256_byte_host #(
    parameter int MIN_WAIT = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] dig_data,
    output logic         err,
    output logic [7:0]   bus_wdata,
    output logic [5:0]   bus_addr,
    output logic         bus_wr,
    input  logic [7:0]   bus_rdata,
    input  logic         hash_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [15:0] MIN_W   = 16'(MIN_WAIT);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nx;
    logic [15:0]   cnt;
    logic [15:0]   cnt_nx;
    logic [511:0]  blk_q;
    logic [255:0]  dig_q;
    logic          err_q;
    logic          err_nx;
    logic          load;
    logic          cap;
    logic [4:0]    ridx;

    // Read data lags the address by one cycle, so step r stores byte r-1.
    assign ridx = cnt[4:0] - 5'd1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = 1'b0;
        load     = 1'b0;
        cap      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (blk_valid) begin
                    load     = 1'b1;
                    cnt_nx   = '0;
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt[5:0] == 6'd63) begin
                    cnt_nx   = '0;
                    state_nx = S_WAIT;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            S_WAIT: begin
                if (hash_ready && (cnt >= MIN_W)) begin
                    cnt_nx   = '0;
                    state_nx = S_READ;
                end else if (cnt == TO_LAST) begin
                    cnt_nx   = '0;
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            S_READ: begin
                cap = (cnt != 16'd0);
                if (cnt == 16'd32) begin
                    cnt_nx   = '0;
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            S_DONE: begin
                if (dig_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err_q <= err_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q <= '0;
        end else if (load) begin
            blk_q <= blk_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q <= '0;
        end else if (cap) begin
            dig_q[{ridx, 3'b000} +: 8] <= bus_rdata;
        end
    end

    always_comb begin
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        unique case (1'b1)
            (state == S_WRITE): begin
                bus_wr    = 1'b1;
                bus_addr  = cnt[5:0];
                bus_wdata = blk_q[{cnt[5:0], 3'b000} +: 8];
            end
            (state == S_READ): begin
                if (cnt <= 16'd31) begin
                    bus_addr = {1'b0, cnt[4:0]};
                end
            end
            default: begin
                bus_wr = 1'b0;
            end
        endcase
    end

    // Held low while reset is asserted; rises once reset is released.
    assign blk_ready = (state == S_IDLE) && rst_n;
    assign dig_valid = (state == S_DONE);
    assign dig_data  = dig_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sha256_byte_host.sv
// Scoreboard bench for sha256_byte_host against a behavioural
// model of the byte-bus hashing wrapper.
module tb_sha256_byte_host;

    localparam int MIN_WAIT = 4;
    localparam int TIMEOUT  = 32;

    localparam logic [255:0] ABC_BE =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] ABC_DIG =
        256'had1500f2_61ff10b4_9c7a1796_a36103b0_2322ae5d_de404141_eacf018f_bf1678ba;
    localparam logic [255:0] A0_DIG =
        256'hbfbebdbc_bbbab9b8_b7b6b5b4_b3b2b1b0_afaeadac_abaaa9a8_a7a6a5a4_a3a2a1a0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         dig_valid;
    logic         dig_ready;
    logic [255:0] dig_data;
    logic         err;
    logic [7:0]   bus_wdata;
    logic [5:0]   bus_addr;
    logic         bus_wr;
    logic [7:0]   bus_rdata;
    logic         hash_ready;

    sha256_byte_host #(.MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
        .err(err), .bus_wdata(bus_wdata), .bus_addr(bus_addr),
        .bus_wr(bus_wr), .bus_rdata(bus_rdata), .hash_ready(hash_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wrapper model: registered read port, hash_ready after a delay.
    logic [7:0] md [32];
    logic       hr;
    logic       pend;
    int         dcnt;
    int         delay = 10;
    bit         no_hash = 0;
    bit         force_hr = 0;

    assign hash_ready = hr | force_hr;

    always @(posedge clk) begin
        if (!rst_n) begin
            hr   <= 1'b0;
            pend <= 1'b0;
            dcnt <= 0;
            bus_rdata <= 8'h00;
        end else begin
            bus_rdata <= md[bus_addr[4:0]];
            if (bus_wr && bus_addr == 6'd63) begin
                hr   <= 1'b0;
                pend <= !no_hash;
                dcnt <= delay;
            end else if (pend) begin
                if (dcnt == 0) begin
                    hr   <= 1'b1;
                    pend <= 1'b0;
                end else begin
                    dcnt <= dcnt - 1;
                end
            end
        end
    end

    typedef struct packed {
        bit           is_err;
        logic [255:0] dig;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] wmem [64];
    int         wr_next = 0;
    int         wr_cnt = 0;
    int         last_wr_cyc = 0;
    int         rd1_cyc = -1;
    int         err_cyc = 0;
    int         err_cnt = 0;

    // Monitor: bus write order, idle write data, and scoreboard pops.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_wr) begin
                chk("wr_addr", 256'(bus_addr), 256'(wr_next[5:0]));
                wmem[bus_addr] = bus_wdata;
                wr_next++;
                wr_cnt++;
                last_wr_cyc = cyc;
            end else if (bus_wdata != 8'h00) begin
                chk("wdata_idle", 256'(bus_wdata), 256'd0);
            end
            if (!bus_wr && bus_addr == 6'd1 && rd1_cyc < 0)
                rd1_cyc = cyc;
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
                if (sbq.size() == 0) begin
                    chk("unexpected_err", 256'd1, 256'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("err_kind", 256'(e.is_err), 256'd1);
                end
            end
            if (dig_valid && dig_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_dig", 256'd1, 256'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("dig_kind", 256'(e.is_err), 256'd0);
                    chk("dig_data", dig_data, e.dig);
                end
            end
        end
    end

    task automatic md_be(input logic [255:0] be);
        for (int k = 0; k < 32; k++) md[k] = be[255-8*k -: 8];
    endtask

    task automatic md_a0();
        for (int k = 0; k < 32; k++) md[k] = 8'hA0 + 8'(k);
    endtask

    task automatic send(input logic [511:0] b);
        bit ok;
        ok = 0;
        wr_next = 0;
        wr_cnt  = 0;
        rd1_cyc = -1;
        @(posedge clk);
        #1;
        blk_data  = b;
        blk_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (blk_ready) begin
                ok = 1;
                break;
            end
        end
        chk("blk_accept", 256'(ok), 256'd1);
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 256'(sbq.size()), 256'd0);
        sbq.delete();
    endtask

    task automatic chk_writes(input logic [511:0] b);
        logic [511:0] got;
        for (int k = 0; k < 64; k++) got[8*k +: 8] = wmem[k];
        chk("wr_count", 256'(wr_cnt), 256'd64);
        chk("wr_bytes_lo", got[255:0], b[255:0]);
        chk("wr_bytes_hi", got[511:256], b[511:256]);
    endtask

    logic [511:0] abc;
    logic [511:0] alt;
    exp_t         e;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        abc = '0;
        abc[7:0]     = 8'h61;
        abc[15:8]    = 8'h62;
        abc[23:16]   = 8'h63;
        abc[31:24]   = 8'h80;
        abc[511:504] = 8'h18;
        alt = {16{32'hdeadbeef}};
        for (int k = 0; k < 64; k++) wmem[k] = 8'h00;
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        dig_ready = 1'b1;
        md_be(ABC_BE);

        repeat (3) @(negedge clk);
        chk("rst_blk_ready", 256'(blk_ready), 256'd0);
        chk("rst_dig_valid", 256'(dig_valid), 256'd0);
        chk("rst_err", 256'(err), 256'd0);
        chk("rst_bus_wr", 256'(bus_wr), 256'd0);
        chk("rst_dig_data", dig_data, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 256'(blk_ready), 256'd1);

        // Known vector: padded "abc"
        e.is_err = 0;
        e.dig    = ABC_DIG;
        sbq.push_back(e);
        send(abc);
        drain();
        chk_writes(abc);

        // Read alignment
        md_a0();
        e.dig = A0_DIG;
        sbq.push_back(e);
        send(alt);
        drain();
        chk_writes(alt);

        // Timeout: hash_ready never rises
        no_hash = 1;
        err_cnt = 0;
        e.is_err = 1;
        e.dig    = '0;
        sbq.push_back(e);
        send(abc);
        drain();
        chk("to_latency", 256'(err_cyc - (last_wr_cyc + 1)), 256'd32);
        chk("to_blk_ready", 256'(blk_ready), 256'd1);
        chk("to_dig_valid", 256'(dig_valid), 256'd0);
        @(negedge clk);
        chk("to_err_once", 256'(err_cnt), 256'd1);
        chk("to_err_low", 256'(err), 256'd0);
        chk("to_dig_kept", dig_data, A0_DIG);
        no_hash = 0;

        // Early hash_ready
        force_hr = 1;
        e.is_err = 0;
        e.dig    = A0_DIG;
        sbq.push_back(e);
        send(abc);
        drain();
        chk("early_read", 256'(rd1_cyc - last_wr_cyc), 256'(MIN_WAIT + 3));
        force_hr = 0;

        // Backpressure
        md_be(ABC_BE);
        dig_ready = 1'b0;
        e.dig = ABC_DIG;
        sbq.push_back(e);
        send(abc);
        for (int i = 0; i < 400; i++) begin
            if (dig_valid) break;
            @(negedge clk);
        end
        chk("bp_valid_seen", 256'(dig_valid), 256'd1);
        blk_data  = alt;
        blk_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("bp_valid", 256'(dig_valid), 256'd1);
            chk("bp_data", dig_data, ABC_DIG);
            chk("bp_blk_ready", 256'(blk_ready), 256'd0);
            chk("bp_no_write", 256'(bus_wr), 256'd0);
        end
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        dig_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("bp_ready_back", 256'(blk_ready), 256'd1);

        // Reset mid-WRITE
        md_a0();
        begin
            bit hit;
            hit = 0;
            wr_next = 0;
            @(posedge clk);
            #1;
            blk_data  = abc;
            blk_valid = 1'b1;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (blk_valid && blk_ready) begin
                    @(posedge clk);
                    #1;
                    blk_valid = 1'b0;
                end
                if (bus_wr && bus_addr == 6'd20) begin
                    hit = 1;
                    break;
                end
            end
            chk("rst_k20_seen", 256'(hit), 256'd1);
            blk_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("mid_rst_wr", 256'(bus_wr), 256'd0);
            chk("mid_rst_addr", 256'(bus_addr), 256'd0);
            chk("mid_rst_valid", 256'(dig_valid), 256'd0);
            chk("mid_rst_err", 256'(err), 256'd0);
            chk("mid_rst_dig", dig_data, 256'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        md_be(ABC_BE);
        e.dig = ABC_DIG;
        sbq.push_back(e);
        send(abc);
        drain();
        chk_writes(abc);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
